key_debounce_repeat: RTL



---
 rtl/key_pkg.sv | 25 ++
 rtl/key_sync2.sv | 24 ++
 rtl/key_debounce_repeat.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared key-conditioning definitions: FSM encoding and the key codes
// that the downstream threshold adjuster also decodes.
package key_pkg;

   localparam int KEY_N = 2;

   localparam logic [KEY_N-1:0] KEY_DEC = 2'b01;
   localparam logic [KEY_N-1:0] KEY_INC = 2'b10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      HOLD     = 3'd2,
      REPEAT   = 3'd3,
      DB_REL   = 3'd4
   } key_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for raw active-low buttons; resets to all-ones so a
// reset leaves every key reading as released.
module key_sync2 #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1 <= '1;
         q      <= '1;
      end else begin
         stage1 <= d;
         q      <= stage1;
      end
   end

endmodule

// File: rtl/key_debounce_repeat.sv
// Front-panel key conditioning: synchronise, debounce press/release and
// emit single-cycle key events with optional auto-repeat while held.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no key active, waiting for a press
//   DB_PRESS | key pattern seen, counting stable cycles before accept
//   HOLD     | press accepted, counting towards the first repeat
//   REPEAT   | auto-repeating at the repeat rate
//   DB_REL   | key pattern changed, waiting for a stable release
module key_debounce_repeat
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = 2000000,
   parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 10000000,
   parameter bit          REPEAT_EN           = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_N-1:0] key_in,
   output logic             key_flag,
   output logic [KEY_N-1:0] key_value
);

   localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                          REPEAT_RATE_CYCLES);
   localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

   logic [KEY_N-1:0] key_sync;
   logic [KEY_N-1:0] key_act;

   key_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [KEY_N-1:0] snap, snap_next;
   logic             flag_next;
   logic [KEY_N-1:0] value_next;

   logic act_zero, act_diff, db_done, delay_done, rate_done, cnt_sat;

   key_sync2 #(.W(KEY_N)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_in),
      .q     (key_sync)
   );

   assign key_act    = ~key_sync;
   assign act_zero   = (key_act == '0);
   assign act_diff   = (key_act != snap);
   assign db_done    = (cnt == DB_LAST);
   assign delay_done = REPEAT_EN && (cnt == DELAY_LAST);
   assign rate_done  = REPEAT_EN && (cnt == RATE_LAST);
   assign cnt_sat    = (cnt == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         snap      <= '0;
         key_flag  <= 1'b0;
         key_value <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         snap      <= snap_next;
         key_flag  <= flag_next;
         key_value <= value_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (!act_zero) state_next = DB_PRESS;
         DB_PRESS: begin
            if (act_zero)                  state_next = IDLE;
            else if (!act_diff && db_done) state_next = HOLD;
         end
         HOLD: begin
            if (act_diff)        state_next = DB_REL;
            else if (delay_done) state_next = REPEAT;
         end
         REPEAT:   if (act_diff) state_next = DB_REL;
         DB_REL:   if (act_zero && db_done) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Counter saturates in HOLD/REPEAT so a long hold with repeat disabled never wraps.
   always_comb begin
      cnt_next   = cnt;
      snap_next  = snap;
      flag_next  = 1'b0;
      value_next = key_value;
      case (state)
         IDLE: begin
            if (!act_zero) begin
               snap_next = key_act;
               cnt_next  = '0;
            end
         end
         DB_PRESS: begin
            if (act_zero) begin
               cnt_next = cnt;
            end else if (act_diff) begin
               snap_next = key_act;
               cnt_next  = '0;
            end else if (db_done) begin
               flag_next  = 1'b1;
               value_next = snap;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (act_diff) begin
               cnt_next = '0;
            end else if (delay_done) begin
               flag_next = 1'b1;
               cnt_next  = '0;
            end else if (!cnt_sat) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (act_diff) begin
               cnt_next = '0;
            end else if (rate_done) begin
               flag_next = 1'b1;
               cnt_next  = '0;
            end else if (!cnt_sat) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         DB_REL: begin
            if (!act_zero) begin
               cnt_next = '0;
            end else if (!db_done) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_next  = '0;
            snap_next = '0;
         end
      endcase
   end

endmodule
